i2s_tx_sequencer: RTL and testbench

//  Master-side controller for the I2S transmit shift core. Derives sck and ws from the system

---
 rtl/i2s_tx_sequencer.sv | 150 +++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_sequencer
// Description : I2S master sequencer. Generates sck/ws, buffers one stereo
//               sample and presents it to the shift core once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_sequencer #(
    parameter int DW    = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_left,
    input  logic [DW-1:0]    s_right,
    input  logic             underrun_clr,
    output logic             sck,
    output logic             ws,
    output logic [DW-1:0]    data_left,
    output logic [DW-1:0]    data_right,
    output logic             frame_start,
    output logic             underrun
);

    localparam int               c_BIT_W = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST = c_BIT_W'(DW - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STOP = 2'd2;

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_pend_valid;
    logic [DW-1:0]      r_pend_left;
    logic [DW-1:0]      r_pend_right;

    logic w_tick;
    logic w_fall;
    logic w_frame;
    logic w_accept;
    logic w_underrun_set;

    assign w_tick         = (r_div_cnt == r_div_q);
    assign w_fall         = w_tick & sck;
    // A frame begins on the sck falling edge that returns ws from right to left
    assign w_frame        = w_fall & (r_bit_cnt == c_LAST) & ws;
    assign s_ready        = (r_state == c_RUN) & ~r_pend_valid;
    assign w_accept       = s_valid & s_ready;
    assign w_underrun_set = (r_state == c_RUN) & w_frame & ~r_pend_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_div_q      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_left  <= '0;
            r_pend_right <= '0;
            sck          <= 1'b0;
            ws           <= 1'b0;
            data_left    <= '0;
            data_right   <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_left  <= s_left;
                r_pend_right <= s_right;
            end

            case (r_state)
                c_IDLE: begin
                    sck <= 1'b0;
                    ws  <= 1'b0;
                    if (enable) begin
                        r_state   <= c_RUN;
                        r_div_q   <= clk_div;
                        ws        <= 1'b1;
                        r_bit_cnt <= c_LAST;
                        r_div_cnt <= '0;
                    end
                end
                default: begin
                    if (w_tick) begin
                        sck       <= ~sck;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end

                    if (w_fall) begin
                        if (r_bit_cnt == c_LAST) begin
                            r_bit_cnt <= '0;
                            ws        <= ~ws;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end

                    if (r_state == c_RUN) begin
                        if (!enable) begin
                            r_state <= c_STOP;
                        end
                        if (w_frame) begin
                            frame_start <= 1'b1;
                            if (r_pend_valid) begin
                                data_left    <= r_pend_left;
                                data_right   <= r_pend_right;
                                r_pend_valid <= 1'b0;
                            end else begin
                                data_left  <= '0;
                                data_right <= '0;
                            end
                        end
                    end else begin
                        // Stopping: the pending sample is kept for the next run
                        if (w_frame) begin
                            r_state    <= c_IDLE;
                            sck        <= 1'b0;
                            ws         <= 1'b0;
                            data_left  <= '0;
                            data_right <= '0;
                        end else if (enable) begin
                            r_state <= c_RUN;
                        end
                    end
                end
            endcase

            if (w_underrun_set) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_sequencer
// Description : Self-checking bench for i2s_tx_sequencer (DW=16, DIV_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  clk_div;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        underrun_clr;
    logic        sck;
    logic        ws;
    logic [15:0] data_left;
    logic [15:0] data_right;
    logic        frame_start;
    logic        underrun;

    i2s_tx_sequencer #(.DW(16), .DIV_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clk_div      (clk_div),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .underrun_clr (underrun_clr),
        .sck          (sck),
        .ws           (ws),
        .data_left    (data_left),
        .data_right   (data_right),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_valid && s_ready) acc <= acc + 1;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  div;
        logic [15:0] left;
        logic [15:0] right;
        int          lat;
        int          per;
        int          frm;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out (cyc=%0d)", nm, cyc);
    endtask

    // Steps at least one cycle, then waits for a frame_start pulse
    task automatic wait_fs(input int maxc, output int t);
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) timeout("wait_frame_start");
        t = cyc;
    endtask

    task automatic wait_sck(input logic lvl, input int maxc);
        int n = 0;
        while (sck !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sck !== lvl) timeout("wait_sck");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        enable       = 1'b0;
        s_valid      = 1'b0;
        underrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {27'd0, sck, ws, frame_start, underrun, s_ready}, 32'd0);
        chk("reset_left", {16'd0, data_left}, 32'd0);
        chk("reset_right", {16'd0, data_right}, 32'd0);
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] smp(input int k);
        return 16'(k * 16'h1111 + 16'h0F0F);
    endfunction

    initial begin
        int t_en, t1, t2, ta, tb2, fu, a0;

        vt[0] = '{div: 8'd1,   left: 16'hA5A5, right: 16'h3C3C, lat: 4,   per: 4,   frm: 128};
        vt[1] = '{div: 8'd0,   left: 16'h8001, right: 16'h7FFE, lat: 2,   per: 2,   frm: 64};
        vt[2] = '{div: 8'd7,   left: 16'hFFFF, right: 16'h0001, lat: 16,  per: 16,  frm: 512};
        vt[3] = '{div: 8'd255, left: 16'h1357, right: 16'h9BDF, lat: 512, per: 512, frm: 16384};

        reset_n = 1'b0; enable = 1'b0; clk_div = 8'd0; s_valid = 1'b0;
        s_left = 16'd0; s_right = 16'd0; underrun_clr = 1'b0;

        // Table: latency, data, sck period, frame period, underrun on empty frame
        for (int i = 0; i < 4; i++) begin
            do_reset();
            clk_div = vt[i].div;
            enable  = 1'b1;
            s_valid = 1'b1;
            s_left  = vt[i].left;
            s_right = vt[i].right;
            t_en    = cyc + 1;
            @(negedge clk);
            clk_div = ~vt[i].div;
            chk("ready_in_run", {31'd0, s_ready}, 32'd1);
            @(negedge clk);
            s_valid = 1'b0;
            chk("ready_when_pending", {31'd0, s_ready}, 32'd0);
            wait_fs(20000, t1);
            chk("first_frame_latency", t1 - t_en, vt[i].lat);
            chk("data_left", {16'd0, data_left}, {16'd0, vt[i].left});
            chk("data_right", {16'd0, data_right}, {16'd0, vt[i].right});
            chk("no_underrun", {31'd0, underrun}, 32'd0);
            wait_sck(1'b1, 2000);
            ta = cyc;
            wait_sck(1'b0, 2000);
            wait_sck(1'b1, 2000);
            tb2 = cyc;
            chk("sck_period", tb2 - ta, vt[i].per);
            wait_fs(40000, t2);
            chk("frame_period", t2 - t1, vt[i].frm);
            chk("empty_left", {16'd0, data_left}, 32'd0);
            chk("empty_right", {16'd0, data_right}, 32'd0);
            chk("underrun_set", {31'd0, underrun}, 32'd1);
        end

        // Back-pressure: one accept per frame, every sample shown once in order
        do_reset();
        a0      = acc;
        clk_div = 8'd0;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_left  = smp(0);
        s_right = ~smp(0);
        @(negedge clk);
        chk("bp_ready0", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_left  = smp(1);
        s_right = ~smp(1);
        for (int k = 0; k < 8; k++) begin
            wait_fs(200, t1);
            chk("bp_left", {16'd0, data_left}, {16'd0, smp(k)});
            chk("bp_right", {16'd0, data_right}, {16'd0, ~smp(k)});
            chk("bp_ready_freed", {31'd0, s_ready}, 32'd1);
            @(negedge clk);
            s_left  = smp(k + 2);
            s_right = ~smp(k + 2);
            chk("bp_ready_refilled", {31'd0, s_ready}, 32'd0);
        end
        s_valid = 1'b0;
        chk("bp_accept_count", acc - a0, 32'd9);
        chk("bp_no_underrun", {31'd0, underrun}, 32'd0);

        // Underrun and its clear
        wait_fs(200, t1);
        chk("last_pending_left", {16'd0, data_left}, {16'd0, smp(8)});
        chk("last_pending_underrun", {31'd0, underrun}, 32'd0);
        wait_fs(200, fu);
        chk("ur_left", {16'd0, data_left}, 32'd0);
        chk("ur_flag", {31'd0, underrun}, 32'd1);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("ur_cleared", {31'd0, underrun}, 32'd0);
        while (cyc < fu + 63) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("ur_clr_frame_pulse", {31'd0, frame_start}, 32'd1);
        chk("ur_set_beats_clr", {31'd0, underrun}, 32'd1);

        // Stop mid-left channel, then restart with the retained pending sample
        do_reset();
        clk_div = 8'd1;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_left  = 16'h1234;
        s_right = 16'h5678;
        @(negedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        wait_fs(200, t1);
        chk("stop_first_left", {16'd0, data_left}, 32'h1234);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = 16'hBEEF;
        s_right = 16'hCAFE;
        @(negedge clk);
        s_valid = 1'b0;
        chk("stop_pended", {31'd0, s_ready}, 32'd0);
        while (cyc < t1 + 20) @(negedge clk);
        enable = 1'b0;
        while (cyc < t1 + 100) @(negedge clk);
        chk("stop_ws_right", {31'd0, ws}, 32'd1);
        while (cyc < t1 + 127) @(negedge clk);
        chk("stop_data_stable", {16'd0, data_left}, 32'h1234);
        @(negedge clk);
        chk("stop_no_pulse", {31'd0, frame_start}, 32'd0);
        chk("stop_sck_ws", {30'd0, sck, ws}, 32'd0);
        chk("stop_data_zero", {data_left, data_right}, 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_quiet", {29'd0, sck, ws, s_ready}, 32'd0);
        enable = 1'b1;
        t_en   = cyc + 1;
        wait_fs(200, t2);
        chk("restart_latency", t2 - t_en, 32'd4);
        chk("restart_left", {16'd0, data_left}, 32'hBEEF);
        chk("restart_right", {16'd0, data_right}, 32'hCAFE);
        chk("restart_no_underrun", {31'd0, underrun}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (cyc=%0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
